// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state encoding, the NOP word and the queue entry layout.
package if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries.
// Head is always slot 0; flush wins over push/pop. DEPTH must be 1..3.
module if_fifo
    import if_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  if_entry_t  din,
    output if_entry_t  head,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    if_entry_t  mem_q [DEPTH];
    if_entry_t  mem_d [DEPTH];
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Shift out the head on pop, then write the new entry behind the tail.
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            if (pop && cnt_q != 2'd0) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i + 1];
                end
                cnt_d = cnt_q - 2'd1;
            end
            if (push && cnt_d < 2'(DEPTH)) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (2'(i) == cnt_d) begin
                        mem_d[i] = din;
                    end
                end
                cnt_d = cnt_d + 2'd1;
            end
        end
    end

    // Storage and occupancy; slots reset to a NOP at RESET_PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: RESET_PC, instr: NOP};
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign head  = mem_q[0];
    assign empty = (cnt_q == 2'd0);
    assign full  = (cnt_q == 2'(DEPTH));
    assign count = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC, imem req/ack, output queue, redirect and halt.
// IF_PREFETCH_BUF_EN: 2-entry prefetch queue, else one output register.
module instr_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_in_if,
    input  logic        redirect_in_if,
    input  logic [31:0] redirect_pc_in_if,
    input  logic        halt_in_if,
    output logic        valid_out_if,
    output logic [31:0] instr_out_if,
    output logic [31:0] pc_out_if,
    output logic        halt_out_if
);

`ifdef IF_PREFETCH_BUF_EN
    localparam int QDEPTH = 2;
`else
    localparam int QDEPTH = 1;
`endif

    if_state_e   state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] addr_q;
    logic        req_q;
    logic        drain_halt_q;
    logic        mis_valid_q;
    logic        halt_q;
    logic [31:0] mis_pc_q;

    logic        ack_acc;
    logic        active;
    logic        mis_tgt;
    logic        room;
    logic [31:0] pc_inc;
    logic [1:0]  cnt_next;
    logic        q_push;
    logic        q_pop;
    logic        q_flush;
    logic        q_full;
    logic        q_empty;
    logic [1:0]  q_count;
    if_entry_t   q_din;
    if_entry_t   q_head;

    // Queue control and the room check that gates the next request.
    always_comb begin
        ack_acc  = req_q && imem_ack;
        active   = (state_q != HALTED);
        mis_tgt  = (redirect_pc_in_if[1:0] != 2'b00);
        q_flush  = active && (halt_in_if || redirect_in_if);
        q_pop    = !q_empty && !mis_valid_q && !stall_in_if;
        q_push   = (state_q == RUN) && ack_acc && !halt_in_if &&
                   !redirect_in_if && (!q_full || q_pop);
        cnt_next = q_count + {1'b0, q_push} - {1'b0, q_pop};
        room     = (cnt_next < 2'(QDEPTH));
        pc_inc   = fetch_pc_q + 32'd4;
        q_din    = '{pc: addr_q, instr: imem_rdata};
    end

    if_fifo #(
        .DEPTH   (QDEPTH),
        .RESET_PC(RESET_PC)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (q_push),
        .pop  (q_pop),
        .flush(q_flush),
        .din  (q_din),
        .head (q_head),
        .full (q_full),
        .empty(q_empty),
        .count(q_count)
    );

    // FSM: halt beats redirect, redirect beats ack/stall, then normal fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= RUN;
            fetch_pc_q   <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            drain_halt_q <= 1'b0;
            mis_valid_q  <= 1'b0;
            halt_q       <= 1'b0;
            mis_pc_q     <= RESET_PC;
        end else begin
            if (mis_valid_q && !stall_in_if) begin
                mis_valid_q <= 1'b0;
            end
            if (active) begin
                if (halt_in_if) begin
                    mis_valid_q <= 1'b0;
                    if (req_q && !imem_ack) begin
                        state_q      <= DRAIN;
                        drain_halt_q <= 1'b1;
                    end else begin
                        state_q <= HALTED;
                        req_q   <= 1'b0;
                    end
                end else if (redirect_in_if) begin
                    fetch_pc_q <= redirect_pc_in_if;
                    if (mis_tgt) begin
                        mis_valid_q <= 1'b1;
                        halt_q      <= 1'b1;
                        mis_pc_q    <= redirect_pc_in_if;
                    end
                    if (req_q && !imem_ack) begin
                        state_q      <= DRAIN;
                        drain_halt_q <= drain_halt_q || mis_tgt;
                    end else if (mis_tgt || drain_halt_q) begin
                        state_q <= HALTED;
                        req_q   <= 1'b0;
                    end else begin
                        state_q <= RUN;
                        req_q   <= 1'b1;
                        addr_q  <= redirect_pc_in_if;
                    end
                end else if (state_q == DRAIN) begin
                    if (ack_acc) begin
                        if (drain_halt_q) begin
                            state_q <= HALTED;
                            req_q   <= 1'b0;
                        end else begin
                            state_q <= RUN;
                            req_q   <= 1'b1;
                            addr_q  <= fetch_pc_q;
                        end
                    end
                end else begin
                    if (ack_acc) begin
                        fetch_pc_q <= pc_inc;
                    end
                    if (!req_q || imem_ack) begin
                        req_q  <= room;
                        addr_q <= ack_acc ? pc_inc : fetch_pc_q;
                    end
                end
            end
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign valid_out_if = mis_valid_q || !q_empty;
    assign pc_out_if    = halt_q ? mis_pc_q : q_head.pc;
    assign instr_out_if = halt_q ? NOP : q_head.instr;
    assign halt_out_if  = halt_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the pipelined RV32I CPU; the producer end of the instruction stream consumed by the decode stage. It holds the fetch PC and issues word requests to instruction memory over a req/ack handshake. Returned words are buffered and presented to decode as {instr, pc, halt}. The block handles stalls, branch/jump redirects and halt propagation.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- imem_req  out  1  request valid; held until imem_ack
- imem_addr  out  32  word address; stable while imem_req high
- imem_ack  in  1  rdata valid; may assert in the same cycle as imem_req
- imem_rdata  in  32  instruction word, valid when imem_ack
- stall_in_if  in  1  decode cannot accept; outputs hold
- redirect_in_if  in  1  branch/jump taken (from EX)
- redirect_pc_in_if  in  32  redirect target
- halt_in_if  in  1  downstream halt; stop fetching
- valid_out_if  out  1  instr_out_if/pc_out_if meaningful
- instr_out_if  out  32  instruction to decode
- pc_out_if  out  32  PC of instr_out_if
- halt_out_if  out  1  fetch-side halt (misaligned target)

## Operation
- Reset values: imem_req 0, imem_addr RESET_PC, valid_out_if 0, instr_out_if 32'h0000_0013 (NOP), pc_out_if RESET_PC, halt_out_if 0, queue empty, state RUN.
- Handshake: at most one request outstanding. imem_ack is ignored while imem_req is low. fetch_pc += 4 on each accepted ack (32-bit wrap at 32'hFFFF_FFFC -> 0).
- A new request is issued only if the queue has room for it counting the outstanding one.
- Output: the queue head drives the outputs. The head pops when valid_out_if && !stall_in_if.
- FSM states:
  - RUN: fetch normally.
  - DRAIN: a redirect occurred while a request was outstanding. Hold req/addr until ack, discard the data, then request the redirect target and return to RUN.
  - HALTED: imem_req stays 0 and valid_out_if stays 0. Only reset exits.
- Redirect behaviour:
  - Redirect takes priority over stall and over a simultaneous ack. The queue flushes and valid_out_if is 0 in the next cycle.
  - fetch_pc loads redirect_pc_in_if.
  - If no request is outstanding (or the ack arrives in the redirect cycle), the next request goes to the target directly.
- Misaligned target (redirect_pc_in_if[1:0] != 0):
  - Flush the queue.
  - Next cycle: halt_out_if=1, valid_out_if=1, pc_out_if=target, instr_out_if=NOP.
  - Then enter HALTED (via DRAIN if a request is outstanding).
- halt_in_if:
  - No new requests are issued.
  - An outstanding request completes and its data is discarded.
  - Queue flushes; enter HALTED. halt_out_if stays 0.
- Simultaneous events: halt_in_if has priority over redirect.
- Reset mid-request: the request is dropped (imem_req=0 next cycle). Memory must tolerate an abandoned request.

## Timing
- The ack-to-output path is registered: an ack in cycle N with an empty queue gives valid_out_if=1 in cycle N+1.
- First imem_req asserts in the first cycle after rst deasserts.
- With zero-wait memory and no stall, throughput is 1 instr/cycle with the buffer and 1 per 2 cycles without.
- Redirect in cycle N: imem_addr=target by N+1 if no request is outstanding. The first redirected instruction appears at N+2 at the earliest.
- Stall holds all outputs unchanged; fetching continues until the queue is full.

## Configuration
- IF_PREFETCH_BUF_EN defined: 2-entry queue (if_fifo); requests continue while the head is stalled.
- IF_PREFETCH_BUF_EN undefined: a single output register. A request is issued only when that register is empty. No other behaviour changes.

## Structure
- Package if_pkg holds:
  - FSM state enum (RUN, DRAIN, HALTED)
  - NOP constant 32'h0000_0013
  - queue entry struct {pc, instr}
  - default RESET_PC
- Sub-module if_fifo: 2-entry synchronous FIFO with push, pop, flush, full, empty and count.

## Test plan
- Reset release, zero-wait memory returning addr+1000: pc_out_if 0,4,8 on consecutive cycles starting 2 cycles after release; instr 1000,1004,1008.
- Stall for 3 cycles with queue filling: outputs frozen; at most 2 buffered plus 1 outstanding; no instruction lost or duplicated after stall release.
- Redirect to 32'h100 while a 3-cycle-latency request to 32'h8 is outstanding: the 32'h8 data is discarded; next imem_addr is 32'h100; next valid pc_out_if is 32'h100.
- Redirect to 32'h102: halt_out_if=1 with pc_out_if=32'h102; imem_req stays 0 thereafter.
- halt_in_if asserted together with a redirect: no request to the redirect target; valid_out_if=0 until reset.
- rst low during an outstanding request: imem_req=0 next cycle; refetch from RESET_PC after release.
